lfsr_gen: RTL and testbench

Parametrised Galois LFSR pseudo-random source with a seed-load port, leap-forward stepping and a valid/ready output handshake. It is the next generation of the team's 8-bit random-number block. Typical consumers are test-pattern generators, arbitration tie-breakers and scramblers, which request a number and take it through the handshake. A warm-up phase after reset or seed load discards the first WARMUP clocks of the sequence.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_gen_if.sv | 28 ++
 rtl/lfsr_leap.sv | 25 ++
 rtl/lfsr_gen.sv | 104 ++++++++++
 tb/tb_lfsr_gen.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the lfsr_gen pseudo-random source.
package lfsr_pkg;

  typedef enum logic {WARM, RUN} lfsr_state_e;

  // Maximal-length Galois feedback masks for common widths
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;
  localparam logic [63:0] TAPS_64 = 64'hD800000000000000;

  localparam int DROP_W = 8;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Seed, advance and number handshake bundle between a consumer (master) and lfsr_gen (slave).
interface lfsr_gen_if
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic              seed_we;
  logic [WIDTH-1:0]  seed;
  logic              enable;
  logic              req;
  logic              num_ready;
  logic              num_valid;
  logic [WIDTH-1:0]  num_out;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output seed_we, seed, enable, req, num_ready,
    input  num_valid, num_out, busy, drop_cnt
  );

  modport slave (
    input  seed_we, seed, enable, req, num_ready,
    output num_valid, num_out, busy, drop_cnt
  );

endinterface

// File: rtl/lfsr_leap.sv
// Combinational leap-forward: applies the Galois step STEPS times in one clock.
module lfsr_leap
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8),
  parameter int               STEPS = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] state_next
);

  logic [WIDTH-1:0] chain [STEPS+1];

  assign chain[0] = state;

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
      assign chain[gi+1] = (chain[gi] >> 1) ^ (chain[gi][0] ? TAPS : '0);
    end
  endgenerate

  assign state_next = chain[STEPS];

endmodule

// File: rtl/lfsr_gen.sv
// Galois LFSR source with seed load, warm-up, leap stepping and valid/ready output.
// Optional LFSR_LOCKUP_GUARD_EN: zero seeds and an all-zero state fall back to RESET_SEED.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(TAPS_8),
  parameter int               STEPS      = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(8'h0C),
  parameter int               WARMUP     = 0
) (
  input logic       clk,
  input logic       rst,
  lfsr_gen_if.slave bus
);

  localparam logic [7:0]  WARM_INIT = 8'(WARMUP);
  localparam lfsr_state_e FSM_INIT  = (WARMUP != 0) ? WARM : RUN;

  lfsr_state_e       fsm_reg;
  logic [7:0]        warm_cnt_reg;
  logic [WIDTH-1:0]  lfsr_reg;
  logic              num_valid_reg;
  logic [WIDTH-1:0]  num_out_reg;
  logic              busy_reg;
  logic [DROP_W-1:0] drop_cnt_reg;

  logic [WIDTH-1:0]  leap_next;
  logic [WIDTH-1:0]  seed_eff;
  logic              accept;
  logic              refuse;
  logic              advance;
  logic              lock;

  lfsr_leap #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_leap (
    .state      (lfsr_reg),
    .state_next (leap_next)
  );

  always_comb begin
    accept  = bus.req && (fsm_reg == RUN) && (!num_valid_reg || bus.num_ready);
    refuse  = bus.req && !accept;
    advance = (fsm_reg == WARM) || bus.enable;
`ifdef LFSR_LOCKUP_GUARD_EN
    seed_eff = (bus.seed == '0) ? RESET_SEED : bus.seed;
    lock     = (lfsr_reg == '0);
`else
    seed_eff = bus.seed;
    lock     = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg      <= RESET_SEED;
      fsm_reg       <= FSM_INIT;
      warm_cnt_reg  <= WARM_INIT;
      busy_reg      <= (FSM_INIT == WARM);
      num_valid_reg <= 1'b0;
      num_out_reg   <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      // Capture uses the pre-update state, so a concurrent seed load still yields the old value
      if (accept) begin
        num_out_reg   <= lfsr_reg;
        num_valid_reg <= 1'b1;
      end else if (num_valid_reg && bus.num_ready) begin
        num_valid_reg <= 1'b0;
      end

      if (refuse) drop_cnt_reg <= sat_inc(drop_cnt_reg);

      if (bus.seed_we) begin
        lfsr_reg     <= seed_eff;
        fsm_reg      <= FSM_INIT;
        warm_cnt_reg <= WARM_INIT;
        busy_reg     <= (FSM_INIT == WARM);
      end else begin
        if (lock) lfsr_reg <= RESET_SEED;
        else if (advance) lfsr_reg <= leap_next;

        if (fsm_reg == WARM) begin
          if (warm_cnt_reg == 8'd1) begin
            fsm_reg      <= RUN;
            busy_reg     <= 1'b0;
            warm_cnt_reg <= '0;
          end else begin
            warm_cnt_reg <= warm_cnt_reg - 8'd1;
          end
        end
      end
    end
  end

  assign bus.num_valid = num_valid_reg;
  assign bus.num_out   = num_out_reg;
  assign bus.busy      = busy_reg;
  assign bus.drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed and randomized checks of lfsr_gen against a behavioural reference model.
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] m_s, m_out, m_drop;
  logic       m_valid;
  logic [7:0] exp_seq [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
  logic [7:0] exp_zero;

  always #5 clk = ~clk;

  lfsr_gen_if #(.WIDTH(8)) i0 ();
  lfsr_gen_if #(.WIDTH(8)) i1 ();
  lfsr_gen_if #(.WIDTH(8)) i2 ();

  lfsr_gen #(.WIDTH(8)) u0 (.clk(clk), .rst(rst), .bus(i0));
  lfsr_gen #(.WIDTH(8), .STEPS(4)) u_leap4 (.clk(clk), .rst(rst), .bus(i1));
  lfsr_gen #(.WIDTH(8), .WARMUP(3)) u_warm3 (.clk(clk), .rst(rst), .bus(i2));

  // n applications of next = (s >> 1) ^ (s[0] ? 0xB8 : 0)
  function automatic logic [7:0] adv(input logic [7:0] s, input int n);
    logic [7:0] v = s;
    for (int k = 0; k < n; k++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of instance u0 (WARMUP=0, STEPS=1) for the edge about to happen
  task automatic model_edge();
    logic acc;
    if (rst) begin
      m_s = 8'h0C; m_valid = 1'b0; m_out = 8'h00; m_drop = 8'h00;
    end else begin
      acc = i0.req && (!m_valid || i0.num_ready);
      if (i0.req && !acc && m_drop != 8'd255) m_drop = m_drop + 8'd1;
      if (acc) begin
        m_out = m_s; m_valid = 1'b1;
      end else if (m_valid && i0.num_ready) begin
        m_valid = 1'b0;
      end
`ifdef LFSR_LOCKUP_GUARD_EN
      if (i0.seed_we) m_s = (i0.seed == 8'h00) ? 8'h0C : i0.seed;
      else if (m_s == 8'h00) m_s = 8'h0C;
      else if (i0.enable) m_s = adv(m_s, 1);
`else
      if (i0.seed_we) m_s = i0.seed;
      else if (i0.enable) m_s = adv(m_s, 1);
`endif
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    i0.seed_we = 0; i0.seed = 0; i0.enable = 0; i0.req = 0; i0.num_ready = 0;
    i1.seed_we = 0; i1.seed = 0; i1.enable = 0; i1.req = 0; i1.num_ready = 0;
    i2.seed_we = 0; i2.seed = 0; i2.enable = 0; i2.req = 0; i2.num_ready = 0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_valid", i0.num_valid, 0);
    chk("rst_out", i0.num_out, 0);
    chk("rst_drop", i0.drop_cnt, 0);
    chk("rst_busy_w0", i0.busy, 0);
    chk("rst_busy_w3", i2.busy, 1);
    rst = 1'b0;

    // First request after reset returns RESET_SEED
    i0.req = 1; i0.num_ready = 1;
    tick();
    i0.req = 0;
    chk("first_valid", i0.num_valid, 1);
    chk("first_out", i0.num_out, 8'h0C);
    $display("txn first out=%h valid=%b", i0.num_out, i0.num_valid);
    tick();
    chk("valid_clear", i0.num_valid, 0);

    // Seed 0x01, request every enabled clock
    i0.seed_we = 1; i0.seed = 8'h01;
    tick();
    i0.seed_we = 0; i0.enable = 1; i0.req = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("seq", i0.num_out, exp_seq[k]);
      $display("txn seq %0d out=%h", k, i0.num_out);
    end
    i0.req = 0;
    repeat (249) tick();
    i0.req = 1; i0.enable = 0;
    tick();
    chk("period255", i0.num_out, 8'h01);
    $display("txn period out=%h", i0.num_out);

    // Backpressure: refused requests leave the held number alone
    i0.req = 0; i0.num_ready = 0; i0.enable = 1;
    for (int k = 0; k < 3; k++) begin
      i0.req = 1; tick();
      i0.req = 0; tick();
      $display("txn refused %0d drop=%0d", k, i0.drop_cnt);
    end
    chk("bp_out", i0.num_out, 8'h01);
    chk("bp_valid", i0.num_valid, 1);
    chk("bp_drop", i0.drop_cnt, 3);
    i0.req = 1; i0.num_ready = 1; i0.enable = 0;
    tick();
    i0.req = 0;
    chk("bp_take_out", i0.num_out, adv(8'h01, 6));
    chk("bp_take_valid", i0.num_valid, 1);
    $display("txn take out=%h", i0.num_out);

    // Randomized traffic against the model
    for (int t = 0; t < 200; t++) begin
      i0.req       = 1'($urandom_range(0, 1));
      i0.num_ready = 1'($urandom_range(0, 1));
      i0.enable    = 1'($urandom_range(0, 1));
      i0.seed_we   = ($urandom_range(0, 15) == 0);
      i0.seed      = 8'($urandom_range(1, 255));
      tick();
      chk("rnd_valid", i0.num_valid, m_valid);
      chk("rnd_out", i0.num_out, m_out);
      chk("rnd_drop", i0.drop_cnt, m_drop);
      $display("txn rnd %0d req=%b rdy=%b en=%b sw=%b valid=%b out=%h drop=%0d",
               t, i0.req, i0.num_ready, i0.enable, i0.seed_we,
               i0.num_valid, i0.num_out, i0.drop_cnt);
    end
    i0.seed_we = 0;

    // Drop counter saturation
    i0.req = 1; i0.num_ready = 1;
    tick();
    i0.num_ready = 0;
    repeat (260) tick();
    i0.req = 0;
    chk("drop_sat", i0.drop_cnt, 8'd255);
    chk("drop_sat_model", i0.drop_cnt, m_drop);
    $display("txn saturate drop=%0d", i0.drop_cnt);

    // Zero seed
`ifdef LFSR_LOCKUP_GUARD_EN
    exp_zero = 8'h0C;
`else
    exp_zero = 8'h00;
`endif
    i0.seed_we = 1; i0.seed = 8'h00;
    tick();
    i0.seed_we = 0; i0.req = 1; i0.num_ready = 1; i0.enable = 1;
    tick();
    chk("zero_first", i0.num_out, exp_zero);
    for (int t = 0; t < 300; t++) begin
      tick();
      chk("zero_run", i0.num_out, m_out);
    end
    $display("txn zero_seed out=%h", i0.num_out);

    // Reset mid-handshake
    i0.num_ready = 0; i0.req = 0; i0.enable = 0;
    chk("pre_rst_valid", i0.num_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", i0.num_valid, 0);
    chk("midrst_drop", i0.drop_cnt, 0);
    chk("midrst_out", i0.num_out, 0);
    $display("txn midrst valid=%b drop=%0d", i0.num_valid, i0.drop_cnt);

    // Leap-forward by 4
    i1.seed_we = 1; i1.seed = 8'h01;
    tick();
    i1.seed_we = 0; i1.enable = 1; i1.req = 1; i1.num_ready = 1;
    tick();
    chk("leap_seed", i1.num_out, 8'h01);
    tick();
    chk("leap_1", i1.num_out, 8'h17);
    tick();
    chk("leap_2", i1.num_out, adv(8'h17, 4));
    $display("txn leap out=%h", i1.num_out);
    i1.enable = 0; i1.req = 0;

    // Warm-up of 3 clocks after seed load
    i2.seed_we = 1; i2.seed = 8'h01;
    tick();
    i2.seed_we = 0;
    chk("warm_busy0", i2.busy, 1);
    i2.req = 1; i2.num_ready = 1; i2.enable = 0;
    tick();
    i2.req = 0;
    chk("warm_busy1", i2.busy, 1);
    chk("warm_drop", i2.drop_cnt, 1);
    chk("warm_novalid", i2.num_valid, 0);
    tick();
    chk("warm_busy2", i2.busy, 1);
    tick();
    chk("warm_done", i2.busy, 0);
    i2.enable = 1;
    tick();
    i2.enable = 0; i2.req = 1;
    tick();
    i2.req = 0;
    chk("warm_out", i2.num_out, 8'h17);
    chk("warm_valid", i2.num_valid, 1);
    chk("warm_drop_end", i2.drop_cnt, 1);
    $display("txn warm out=%h drop=%0d", i2.num_out, i2.drop_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
